// File: rtl/ext_host_pkg.sv
// Command/status codes and FSM state type for the byte-stream TL-UL host.
package ext_host_pkg;

    localparam logic [7:0] CmdWrite   = 8'h01;
    localparam logic [7:0] CmdRead    = 8'h02;

    localparam logic [7:0] StOk       = 8'h00;
    localparam logic [7:0] StBusErr   = 8'h01;
    localparam logic [7:0] StMisalign = 8'h02;
    localparam logic [7:0] StBadCmd   = 8'hFF;

    typedef enum logic [2:0] {
        S_IDLE    = 3'd0,
        S_ADDR    = 3'd1,
        S_DATA    = 3'd2,
        S_REQ     = 3'd3,
        S_RSP     = 3'd4,
        S_TX_STAT = 3'd5,
        S_TX_DATA = 3'd6
    } state_e;

endpackage

// File: rtl/tlul_pkg.sv
// Minimal TL-UL type definitions used by the external host port.
package tlul_pkg;

    localparam int TL_AW  = 32;
    localparam int TL_DW  = 32;
    localparam int TL_AIW = 8;
    localparam int TL_DIW = 1;
    localparam int TL_SZW = 2;
    localparam int TL_DBW = TL_DW / 8;

    typedef enum logic [2:0] {
        PutFullData    = 3'h0,
        PutPartialData = 3'h1,
        Get            = 3'h4
    } tl_a_op_e;

    typedef enum logic [2:0] {
        AccessAck     = 3'h0,
        AccessAckData = 3'h1
    } tl_d_op_e;

    typedef struct packed {
        logic [4:0] rsvd;
        logic [1:0] instr_type;
    } tl_a_user_t;

    localparam tl_a_user_t TL_A_USER_DEFAULT = '0;

    typedef struct packed {
        logic                a_valid;
        tl_a_op_e            a_opcode;
        logic [2:0]          a_param;
        logic [TL_SZW-1:0]   a_size;
        logic [TL_AIW-1:0]   a_source;
        logic [TL_AW-1:0]    a_address;
        logic [TL_DBW-1:0]   a_mask;
        logic [TL_DW-1:0]    a_data;
        tl_a_user_t          a_user;
        logic                d_ready;
    } tl_h2d_t;

    typedef struct packed {
        logic                d_valid;
        tl_d_op_e            d_opcode;
        logic [2:0]          d_param;
        logic [TL_SZW-1:0]   d_size;
        logic [TL_AIW-1:0]   d_source;
        logic [TL_DIW-1:0]   d_sink;
        logic [TL_DW-1:0]    d_data;
        logic                d_user;
        logic                d_error;
        logic                a_ready;
    } tl_d2h_t;

endpackage

// File: rtl/tlul_ext_host.sv
// Byte-stream command decoder acting as a single-outstanding TL-UL initiator.
// Frames: 01 A0..A3 D0..D3 (write) or 02 A0..A3 (read), little-endian.
// Replies: one status byte, followed by 4 read-data bytes for bus reads.
module tlul_ext_host
    import tlul_pkg::*;
    import ext_host_pkg::*;
#(
    parameter logic [TL_AIW-1:0] SourceId  = '0,
    parameter int unsigned       RxTimeout = 1000000
) (
    input  logic       clk_i,
    input  logic       rst_ni,
    output tl_h2d_t    tl_o,
    input  tl_d2h_t    tl_i,
    input  logic [7:0] rx_data_i,
    input  logic       rx_valid_i,
    output logic       rx_ready_o,
    output logic [7:0] tx_data_o,
    output logic       tx_valid_o,
    input  logic       tx_ready_i,
    output logic       busy_o
);

    // Counter value on which a stalled frame is abandoned (0 disables).
    localparam logic [31:0] TmoLast = (RxTimeout == 0) ? 32'd0 : 32'(RxTimeout - 1);

    state_e      r_state;
    state_e      w_state_d;
    logic        r_is_read;
    logic [31:0] r_addr;
    logic [31:0] r_wdata;
    logic [31:0] r_rdata;
    logic [7:0]  r_status;
    logic [1:0]  r_cnt;
    logic [31:0] r_tmo;

    logic w_a_valid;
    logic w_d_ready;
    logic w_rx_fire;
    logic w_a_fire;
    logic w_d_fire;
    logic w_tx_fire;
    logic w_cmd_ok;
    logic w_tmo_hit;
    logic w_rsp_ok;
    logic w_unused_tl;

    assign rx_ready_o = (r_state == S_IDLE) || (r_state == S_ADDR) || (r_state == S_DATA);
    assign tx_valid_o = (r_state == S_TX_STAT) || (r_state == S_TX_DATA);
    assign busy_o     = (r_state != S_IDLE);
    assign w_a_valid  = (r_state == S_REQ);
    assign w_d_ready  = (r_state == S_RSP);

    assign tx_data_o  = (r_state == S_TX_STAT) ? r_status :
                        (r_state == S_TX_DATA) ? r_rdata[{r_cnt, 3'b000} +: 8] : 8'h00;

    assign w_rx_fire  = rx_valid_i & rx_ready_o;
    assign w_a_fire   = w_a_valid & tl_i.a_ready;
    assign w_d_fire   = w_d_ready & tl_i.d_valid;
    assign w_tx_fire  = tx_valid_o & tx_ready_i;
    assign w_cmd_ok   = (rx_data_i == CmdWrite) || (rx_data_i == CmdRead);
    assign w_tmo_hit  = (RxTimeout != 0) && !w_rx_fire && (r_tmo == TmoLast);
    assign w_rsp_ok   = !tl_i.d_error &&
                        (tl_i.d_opcode == (r_is_read ? AccessAckData : AccessAck));

    // Response fields this host has no use for (single source, fixed size).
    assign w_unused_tl = ^{tl_i.d_param, tl_i.d_size, tl_i.d_source, tl_i.d_sink, tl_i.d_user};

    // A-channel request: all fields come from registers, so they hold while a_valid is up.
    always_comb begin
        tl_o           = '0;
        tl_o.a_valid   = w_a_valid;
        tl_o.a_opcode  = r_is_read ? Get : PutFullData;
        tl_o.a_param   = 3'd0;
        tl_o.a_size    = 2'd2;
        tl_o.a_source  = SourceId;
        tl_o.a_address = {r_addr[31:2], 2'b00};
        tl_o.a_mask    = 4'hF;
        tl_o.a_data    = r_is_read ? 32'd0 : r_wdata;
        tl_o.a_user    = TL_A_USER_DEFAULT;
        tl_o.d_ready   = w_d_ready;
    end

    // State register.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) r_state <= S_IDLE;
        else         r_state <= w_state_d;
    end

    // Next-state decode.
    always_comb begin
        w_state_d = r_state;
        case (r_state)
            S_IDLE:    if (w_rx_fire) w_state_d = w_cmd_ok ? S_ADDR : S_TX_STAT;
            S_ADDR: begin
                if (w_rx_fire && r_cnt == 2'd3) begin
                    if (r_addr[1:0] != 2'b00) w_state_d = S_TX_STAT;
                    else                      w_state_d = r_is_read ? S_REQ : S_DATA;
                end else if (w_tmo_hit) begin
                    w_state_d = S_IDLE;
                end
            end
            S_DATA: begin
                if (w_rx_fire && r_cnt == 2'd3) w_state_d = S_REQ;
                else if (w_tmo_hit)             w_state_d = S_IDLE;
            end
            S_REQ:     if (w_a_fire) w_state_d = S_RSP;
            S_RSP:     if (w_d_fire) w_state_d = S_TX_STAT;
            S_TX_STAT: if (w_tx_fire) begin
                w_state_d = (r_is_read && (r_status == StOk || r_status == StBusErr)) ?
                            S_TX_DATA : S_IDLE;
            end
            S_TX_DATA: if (w_tx_fire && r_cnt == 2'd3) w_state_d = S_IDLE;
            default:   w_state_d = S_IDLE;
        endcase
    end

    // Frame capture, response capture, byte counter and inter-byte timeout.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            r_is_read <= 1'b0;
            r_addr    <= '0;
            r_wdata   <= '0;
            r_rdata   <= '0;
            r_status  <= '0;
            r_cnt     <= '0;
            r_tmo     <= '0;
        end else begin
            case (r_state)
                S_IDLE: if (w_rx_fire) begin
                    r_cnt <= 2'd0;
                    r_tmo <= '0;
                    if (w_cmd_ok) begin
                        r_is_read <= (rx_data_i == CmdRead);
                    end else begin
                        r_is_read <= 1'b0;
                        r_status  <= StBadCmd;
                    end
                end
                S_ADDR, S_DATA: begin
                    if (w_rx_fire) begin
                        if (r_state == S_ADDR) r_addr[{r_cnt, 3'b000} +: 8]  <= rx_data_i;
                        else                   r_wdata[{r_cnt, 3'b000} +: 8] <= rx_data_i;
                        if (r_state == S_ADDR && r_cnt == 2'd3 && r_addr[1:0] != 2'b00)
                            r_status <= StMisalign;
                        r_cnt <= r_cnt + 2'd1;
                        r_tmo <= '0;
                    end else if (w_tmo_hit) begin
                        r_is_read <= 1'b0;
                        r_addr    <= '0;
                        r_wdata   <= '0;
                        r_cnt     <= '0;
                        r_tmo     <= '0;
                    end else begin
                        r_tmo <= r_tmo + 32'd1;
                    end
                end
                S_RSP: if (w_d_fire) begin
                    r_rdata  <= tl_i.d_data;
                    r_status <= w_rsp_ok ? StOk : StBusErr;
                end
                S_TX_DATA: if (w_tx_fire) r_cnt <= r_cnt + 2'd1;
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_tlul_ext_host.sv
// Randomized self-checking bench for tlul_ext_host with a TL-UL slave model,
// a stalling byte sink and a frame-level reference model.
module tb_tlul_ext_host;
    import tlul_pkg::*;

    localparam logic [7:0] SRC = 8'h5A;

    logic       clk = 1'b0;
    logic       rst_n;
    tl_h2d_t    tl_o;
    tl_d2h_t    tl_i;
    logic [7:0] rx_data;
    logic       rx_valid;
    logic       rx_ready;
    logic [7:0] tx_data;
    logic       tx_valid;
    logic       tx_ready;
    logic       busy;

    always #5 clk = ~clk;

    tlul_ext_host #(.SourceId(SRC), .RxTimeout(16)) dut (
        .clk_i     (clk),
        .rst_ni    (rst_n),
        .tl_o      (tl_o),
        .tl_i      (tl_i),
        .rx_data_i (rx_data),
        .rx_valid_i(rx_valid),
        .rx_ready_o(rx_ready),
        .tx_data_o (tx_data),
        .tx_valid_o(tx_valid),
        .tx_ready_i(tx_ready),
        .busy_o    (busy)
    );

    int n_checks = 0;
    int n_fail   = 0;

    // Slave / sink behaviour knobs.
    int          sl_a_delay  = 0;
    logic        sl_err      = 1'b0;
    logic        sl_badop    = 1'b0;
    logic [31:0] sl_rdata    = 32'h0;
    int          tx_stall    = 0;
    int          tx_unstable = 0;

    typedef struct packed {
        logic [2:0]  op;
        logic [2:0]  param;
        logic [1:0]  size;
        logic [7:0]  src;
        logic [31:0] addr;
        logic [3:0]  mask;
        logic [31:0] data;
    } beat_t;

    beat_t      beats[$];
    logic [7:0] txq[$];

    // TL-UL slave: holds a_ready low for sl_a_delay cycles, then answers the cycle after acceptance.
    initial begin
        tl_h2d_t snap;
        int      unstable;
        tl_i = '0;
        forever begin
            @(negedge clk);
            if (rst_n === 1'b1 && tl_o.a_valid === 1'b1) begin
                snap     = tl_o;
                unstable = 0;
                for (int i = 0; i < sl_a_delay; i++) begin
                    tl_i.a_ready = 1'b0;
                    @(negedge clk);
                    if (tl_o !== snap) unstable++;
                end
                tl_i.a_ready = 1'b1;
                beats.push_back('{op: tl_o.a_opcode, param: tl_o.a_param, size: tl_o.a_size,
                                  src: tl_o.a_source, addr: tl_o.a_address, mask: tl_o.a_mask,
                                  data: tl_o.a_data});
                @(negedge clk);
                tl_i.a_ready = 1'b0;
                n_checks++;
                if (unstable != 0) begin
                    n_fail++;
                    $display("FAIL a_stable: %0d cycles with changed A fields, required 0", unstable);
                end
                n_checks++;
                if (tl_o.a_valid !== 1'b0) begin
                    n_fail++;
                    $display("FAIL a_valid_drop: got %b, required 0 the cycle after acceptance", tl_o.a_valid);
                end
                n_checks++;
                if (tl_o.d_ready !== 1'b1) begin
                    n_fail++;
                    $display("FAIL d_ready: got %b, required 1 while awaiting response", tl_o.d_ready);
                end
                tl_i.d_valid  = 1'b1;
                tl_i.d_data   = sl_rdata;
                tl_i.d_error  = sl_err;
                tl_i.d_source = snap.a_source;
                if (snap.a_opcode == Get) tl_i.d_opcode = sl_badop ? AccessAck : AccessAckData;
                else                      tl_i.d_opcode = sl_badop ? AccessAckData : AccessAck;
                @(negedge clk);
                tl_i.d_valid = 1'b0;
                tl_i.d_error = 1'b0;
                tl_i.d_data  = '0;
            end
        end
    end

    // Byte sink: stalls tx_stall cycles per byte and records each accepted byte.
    initial begin
        int         wcnt;
        logic [7:0] held;
        tx_ready = 1'b0;
        wcnt     = 0;
        held     = 8'h00;
        forever begin
            @(negedge clk);
            if (tx_valid === 1'b1) begin
                if (wcnt == 0)             held = tx_data;
                else if (tx_data !== held) tx_unstable++;
                if (wcnt < tx_stall) begin
                    tx_ready = 1'b0;
                    wcnt++;
                end else begin
                    tx_ready = 1'b1;
                    txq.push_back(tx_data);
                    wcnt = 0;
                end
            end else begin
                tx_ready = 1'b0;
                wcnt     = 0;
            end
        end
    end

    initial begin
        #5_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic send_byte(input logic [7:0] b);
        int t;
        t = 0;
        @(negedge clk);
        rx_valid = 1'b1;
        rx_data  = b;
        while (rx_ready !== 1'b1 && t < 200) begin
            @(negedge clk);
            t++;
        end
        if (t >= 200) begin
            n_checks++;
            n_fail++;
            $display("FAIL rx_accept: byte %h never accepted", b);
        end
        @(posedge clk);
        #1;
        rx_valid = 1'b0;
    endtask

    // Waits for the block to return idle; counts cycles where rx_ready was wrongly high.
    task automatic wait_idle(output int rx_bad);
        int t;
        t      = 0;
        rx_bad = 0;
        while (busy === 1'b1 && t < 3000) begin
            @(negedge clk);
            if (busy === 1'b1 && rx_ready !== 1'b0) rx_bad++;
            t++;
        end
        n_checks++;
        if (busy !== 1'b0) begin
            n_fail++;
            $display("FAIL idle_wait: busy=%b after %0d cycles, required 0", busy, t);
        end
        repeat (2) @(negedge clk);
    endtask

    // Sends one frame and compares bus beats and reply bytes with the frame-level model.
    task automatic run_frame(input string name, input logic [71:0] fr, input int len,
                             input logic err, input logic badop, input logic [31:0] rdata,
                             input int adly, input int tstall);
        logic [7:0]  cmd;
        logic [31:0] addr;
        logic [31:0] wdata;
        logic [7:0]  exp_tx[$];
        int          exp_beats;
        beat_t       exp_beat;
        int          rx_bad;
        cmd   = fr[7:0];
        addr  = fr[39:8];
        wdata = fr[71:40];
        sl_err = err; sl_badop = badop; sl_rdata = rdata; sl_a_delay = adly; tx_stall = tstall;
        beats.delete();
        txq.delete();
        tx_unstable = 0;
        exp_beats   = 0;
        exp_beat    = '0;
        if (cmd != 8'h01 && cmd != 8'h02) begin
            exp_tx.push_back(8'hFF);
        end else if (addr % 4 != 0) begin
            exp_tx.push_back(8'h02);
        end else begin
            exp_beats = 1;
            exp_beat  = '{op: (cmd == 8'h01) ? 3'h0 : 3'h4, param: 3'h0, size: 2'd2, src: SRC,
                          addr: addr, mask: 4'hF, data: (cmd == 8'h01) ? wdata : 32'h0};
            exp_tx.push_back((err || badop) ? 8'h01 : 8'h00);
            if (cmd == 8'h02)
                for (int k = 0; k < 4; k++) exp_tx.push_back(rdata[8*k +: 8]);
        end
        for (int i = 0; i < len; i++) send_byte(fr[8*i +: 8]);
        wait_idle(rx_bad);
        n_checks++;
        if (beats.size() != exp_beats) begin
            n_fail++;
            $display("FAIL %s beats: got %0d bus requests, required %0d", name, beats.size(), exp_beats);
        end else if (exp_beats == 1) begin
            n_checks++;
            if (beats[0] !== exp_beat) begin
                n_fail++;
                $display("FAIL %s a_fields: got %h, required %h", name, beats[0], exp_beat);
            end
        end
        n_checks++;
        if (txq.size() != exp_tx.size()) begin
            n_fail++;
            $display("FAIL %s tx_count: got %0d bytes, required %0d", name, txq.size(), exp_tx.size());
        end else begin
            for (int i = 0; i < exp_tx.size(); i++) begin
                n_checks++;
                if (txq[i] !== exp_tx[i]) begin
                    n_fail++;
                    $display("FAIL %s tx_byte%0d: got %h, required %h", name, i, txq[i], exp_tx[i]);
                end
            end
        end
        n_checks++;
        if (tx_unstable != 0 || rx_bad != 0) begin
            n_fail++;
            $display("FAIL %s hold: tx changes while stalled=%0d, rx_ready high while busy=%0d, required 0/0",
                     name, tx_unstable, rx_bad);
        end
    endtask

    task automatic test_reset();
        rst_n = 1'b0; rx_valid = 1'b0; rx_data = 8'h00;
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk); #1;
        n_checks += 6;
        if (tl_o.a_valid !== 1'b0) begin n_fail++; $display("FAIL reset_a_valid: got %b, required 0", tl_o.a_valid); end
        if (tl_o.d_ready !== 1'b0) begin n_fail++; $display("FAIL reset_d_ready: got %b, required 0", tl_o.d_ready); end
        if (tx_valid !== 1'b0)     begin n_fail++; $display("FAIL reset_tx_valid: got %b, required 0", tx_valid); end
        if (tx_data !== 8'h00)     begin n_fail++; $display("FAIL reset_tx_data: got %h, required 00", tx_data); end
        if (rx_ready !== 1'b1)     begin n_fail++; $display("FAIL reset_rx_ready: got %b, required 1", rx_ready); end
        if (busy !== 1'b0)         begin n_fail++; $display("FAIL reset_busy: got %b, required 0", busy); end
    endtask

    task automatic test_write();
        run_frame("write", {8'hDE, 8'hAD, 8'hBE, 8'hEF, 8'h80, 8'h00, 8'h00, 8'h00, 8'h01}, 9,
                  1'b0, 1'b0, 32'h0, 0, 0);
    endtask

    task automatic test_read();
        run_frame("read", {32'h0, 8'h80, 8'h00, 8'h00, 8'h04, 8'h02}, 5,
                  1'b0, 1'b0, 32'h12345678, 0, 0);
        run_frame("read_err", {32'h0, 8'h80, 8'h00, 8'h00, 8'h04, 8'h02}, 5,
                  1'b1, 1'b0, 32'h0, 1, 0);
    endtask

    task automatic test_misalign_badcmd();
        run_frame("misalign", {32'h0, 8'h80, 8'h00, 8'h00, 8'h02, 8'h02}, 5,
                  1'b0, 1'b0, 32'h0, 0, 0);
        run_frame("badcmd", {64'h0, 8'h7A}, 1, 1'b0, 1'b0, 32'h0, 0, 0);
    endtask

    task automatic test_stall();
        run_frame("stall_wr", {32'hCAFEF00D, 32'h00001000, 8'h01}, 9, 1'b0, 1'b0, 32'h0, 10, 5);
        run_frame("stall_rd", {32'h0, 32'h00002008, 8'h02}, 5, 1'b0, 1'b0, 32'hA1B2C3D4, 10, 5);
    endtask

    task automatic test_timeout();
        beats.delete();
        txq.delete();
        send_byte(8'h01);
        send_byte(8'h00);
        repeat (8) @(posedge clk);
        #1;
        n_checks++;
        if (busy !== 1'b1) begin n_fail++; $display("FAIL tmo_early: busy=%b after 8 idle cycles, required 1", busy); end
        repeat (8) @(posedge clk);
        #1;
        n_checks++;
        if (busy !== 1'b0) begin n_fail++; $display("FAIL tmo_abort: busy=%b after 16 idle cycles, required 0", busy); end
        repeat (10) @(negedge clk);
        n_checks++;
        if (txq.size() != 0 || beats.size() != 0) begin
            n_fail++;
            $display("FAIL tmo_silent: got %0d tx bytes and %0d bus requests, required 0/0", txq.size(), beats.size());
        end
        run_frame("after_tmo", {32'h0, 32'h40000010, 8'h02}, 5, 1'b0, 1'b0, 32'h0BADF00D, 0, 1);
    endtask

    task automatic test_mid_reset();
        send_byte(8'h02);
        send_byte(8'h04);
        @(negedge clk);
        rst_n = 1'b0;
        #1;
        n_checks++;
        if (busy !== 1'b0 || rx_ready !== 1'b1) begin
            n_fail++;
            $display("FAIL mid_reset: busy=%b rx_ready=%b, required 0/1", busy, rx_ready);
        end
        @(negedge clk);
        rst_n = 1'b1;
        run_frame("after_reset", {32'h0, 32'h00000100, 8'h02}, 5, 1'b0, 1'b0, 32'h55AA33CC, 0, 0);
    endtask

    task automatic test_random();
        for (int n = 0; n < 24; n++) begin
            logic [7:0]  cmd;
            logic [31:0] addr;
            logic [31:0] wdata;
            int          r;
            int          len;
            r     = $urandom_range(0, 9);
            addr  = $urandom;
            wdata = $urandom;
            if (r < 4)      cmd = 8'h01;
            else if (r < 8) cmd = 8'h02;
            else            cmd = 8'($urandom_range(3, 255));
            if ($urandom_range(0, 3) != 0) addr[1:0] = 2'b00;
            if (cmd != 8'h01 && cmd != 8'h02) len = 1;
            else if (cmd == 8'h01 && addr[1:0] == 2'b00) len = 9;
            else len = 5;
            run_frame("random", {wdata, addr, cmd}, len,
                      ($urandom_range(0, 5) == 0), ($urandom_range(0, 5) == 0), $urandom,
                      $urandom_range(0, 3), $urandom_range(0, 2));
        end
    endtask

    initial begin
        rst_n    = 1'b0;
        rx_valid = 1'b0;
        rx_data  = 8'h00;
        test_reset();
        test_write();
        test_read();
        test_misalign_badcmd();
        test_stall();
        test_timeout();
        test_mid_reset();
        test_random();
        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule
